// File: rtl/kuz_rk_ctrl.sv
// Round-key store controller for the Kuznyechik core.
// Streams NROUNDS round keys into the external round-key RAM, then
// sequences the RAM read address for the cipher datapath: ascending
// for encryption, descending for decryption. A run is refused while the
// key set is missing or only partly loaded.
//
// Handshake: a key word moves when kl_valid & kl_ready are both high on
// a rising edge. kl_valid may rise or fall freely. kl_ready never depends
// on kl_valid. kl_ready is low in RUN, and also in READY while run_start
// is high, so a run request beats a simultaneous key word.
module kuz_rk_ctrl #(
  parameter int LOG2_L  = 4,
  parameter int NROUNDS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kl_valid,
  output logic              kl_ready,
  input  logic [127:0]      kl_data,
  input  logic              run_start,
  input  logic              run_dec,
  input  logic              run_next,
  output logic              run_busy,
  output logic [LOG2_L-1:0] run_idx,
  output logic              run_last,
  output logic              run_done,
  output logic              run_err,
  output logic              keys_ok,
  output logic              ram_we,
  output logic [LOG2_L-1:0] ram_d_a,
  output logic [127:0]      ram_d,
  output logic [LOG2_L-1:0] ram_q_a,
  output logic [1:0]        dbg_state
);

  localparam logic [LOG2_L-1:0] LAST_IDX = LOG2_L'(NROUNDS - 1);
  localparam logic [LOG2_L-1:0] ONE      = LOG2_L'(1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t              r_state;
  logic [LOG2_L-1:0]   r_wcnt;
  logic [LOG2_L-1:0]   r_idx;
  logic                r_dec;
  logic                r_keys_ok;
  logic                r_done;
  logic                r_err;

  state_t              w_state_nxt;
  logic [LOG2_L-1:0]   w_wcnt_nxt;
  logic [LOG2_L-1:0]   w_idx_nxt;
  logic                w_dec_nxt;
  logic                w_keys_ok_nxt;
  logic                w_done_nxt;
  logic                w_err_nxt;

  logic                w_kl_ready;
  logic                w_accept;
  logic                w_in_run;
  logic                w_last;

  assign w_in_run   = (r_state == ST_RUN);
  assign w_kl_ready = !w_in_run && !((r_state == ST_READY) && run_start);
  assign w_accept   = kl_valid && w_kl_ready;
  assign w_last     = w_in_run && (r_dec ? (r_idx == '0) : (r_idx == LAST_IDX));

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_EMPTY;
      r_wcnt    <= '0;
      r_idx     <= '0;
      r_dec     <= 1'b0;
      r_keys_ok <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_idx     <= w_idx_nxt;
      r_dec     <= w_dec_nxt;
      r_keys_ok <= w_keys_ok_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Next-state: key load counting, run sequencing and refusal pulses.
  always_comb begin
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_idx_nxt     = r_idx;
    w_dec_nxt     = r_dec;
    w_keys_ok_nxt = r_keys_ok;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      ST_EMPTY, ST_READY: begin
        if ((r_state == ST_READY) && run_start) begin
          w_idx_nxt   = run_dec ? LAST_IDX : '0;
          w_dec_nxt   = run_dec;
          w_state_nxt = ST_RUN;
        end else begin
          if (run_start) begin
            w_err_nxt = 1'b1;
          end
          // First word of a fresh set invalidates whatever was stored.
          if (w_accept) begin
            if (LAST_IDX == '0) begin
              w_wcnt_nxt    = '0;
              w_keys_ok_nxt = 1'b1;
              w_state_nxt   = ST_READY;
            end else begin
              w_wcnt_nxt    = ONE;
              w_keys_ok_nxt = 1'b0;
              w_state_nxt   = ST_LOAD;
            end
          end
        end
      end

      ST_LOAD: begin
        if (run_start) begin
          w_err_nxt = 1'b1;
        end
        if (w_accept) begin
          if (r_wcnt == LAST_IDX) begin
            w_wcnt_nxt    = '0;
            w_keys_ok_nxt = 1'b1;
            w_state_nxt   = ST_READY;
          end else begin
            w_wcnt_nxt = r_wcnt + ONE;
          end
        end
      end

      ST_RUN: begin
        if (run_next) begin
          if (w_last) begin
            w_idx_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_READY;
          end else begin
            w_idx_nxt = r_dec ? (r_idx - ONE) : (r_idx + ONE);
          end
        end
      end

      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  assign kl_ready  = w_kl_ready;
  assign ram_we    = w_accept;
  assign ram_d_a   = r_wcnt;
  assign ram_d     = kl_data;
  assign ram_q_a   = w_in_run ? r_idx : '0;
  assign run_busy  = w_in_run;
  assign run_idx   = r_idx;
  assign run_last  = w_last;
  assign run_done  = r_done;
  assign run_err   = r_err;
  assign keys_ok   = r_keys_ok;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_kuz_rk_ctrl.sv
// Bench for kuz_rk_ctrl: a behavioural round-key RAM, directed and
// randomized key loads and runs, and an expected-index queue per run.
module tb_kuz_rk_ctrl;

  localparam int NR = 10;
  localparam int LW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              kl_valid = 1'b0;
  logic              kl_ready;
  logic [127:0]      kl_data = '0;
  logic              run_start = 1'b0;
  logic              run_dec = 1'b0;
  logic              run_next = 1'b0;
  logic              run_busy;
  logic [LW-1:0]     run_idx;
  logic              run_last;
  logic              run_done;
  logic              run_err;
  logic              keys_ok;
  logic              ram_we;
  logic [LW-1:0]     ram_d_a;
  logic [127:0]      ram_d;
  logic [LW-1:0]     ram_q_a;
  logic [1:0]        dbg_state;

  kuz_rk_ctrl #(.LOG2_L(LW), .NROUNDS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .kl_valid(kl_valid), .kl_ready(kl_ready), .kl_data(kl_data),
    .run_start(run_start), .run_dec(run_dec), .run_next(run_next),
    .run_busy(run_busy), .run_idx(run_idx), .run_last(run_last),
    .run_done(run_done), .run_err(run_err), .keys_ok(keys_ok),
    .ram_we(ram_we), .ram_d_a(ram_d_a), .ram_d(ram_d),
    .ram_q_a(ram_q_a), .dbg_state(dbg_state)
  );

  // Round-key RAM: synchronous write, combinational read.
  logic [127:0] bram [16];
  always @(posedge clk) if (ram_we) bram[ram_d_a] <= ram_d;

  // ---------------- scoreboard state ----------------
  logic [127:0]  exp_key [NR];
  logic [127:0]  new_key [NR];
  logic [LW-1:0] exp_q [$];
  bit            keys_valid = 1'b0;
  int            n_tests = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [LW-1:0] obs, input int exp);
    n_tests++;
    assert (obs === LW'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic gen_fixed();
    for (int n = 0; n < NR; n++) begin
      logic [7:0] b;
      b = 8'(8'h10 + n);
      new_key[n] = {16{b}};
    end
  endtask

  task automatic gen_random();
    for (int n = 0; n < NR; n++)
      new_key[n] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Reset for one cycle (inputs left as they are during it), then check.
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    kl_valid = 1'b0;
    run_start = 1'b0;
    run_next = 1'b0;
    keys_valid = 1'b0;
    #1;
    chk1("rst_keys_ok", keys_ok, 1'b0);
    chk1("rst_busy", run_busy, 1'b0);
    chka("rst_idx", run_idx, 0);
    chk1("rst_kl_ready", kl_ready, 1'b1);
    chk1("rst_done", run_done, 1'b0);
    chk1("rst_err", run_err, 1'b0);
  endtask

  // run_start while no valid key set: refused with a one-cycle err pulse.
  task automatic refuse();
    run_start = 1'b1;
    run_dec = 1'($urandom_range(0, 1));
    #1;
    chk1("ref_busy0", run_busy, 1'b0);
    tick();
    run_start = 1'b0;
    #1;
    chk1("ref_err", run_err, 1'b1);
    chk1("ref_busy1", run_busy, 1'b0);
    chk1("ref_keys_ok", keys_ok, keys_valid);
    tick();
    #1;
    chk1("ref_err_clr", run_err, 1'b0);
  endtask

  // Load new_key[start..NR-1]; optional refused start at err_beat,
  // random idle gaps up to max_gap, reset at rst_beat.
  task automatic load_keys(input int start, input int err_beat, input int max_gap,
                           input int rst_beat);
    for (int n = start; n < NR; n++) begin
      int g;
      g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (g) begin
        kl_valid = 1'b0;
        kl_data = {$urandom, $urandom, $urandom, $urandom};
        #1;
        chk1("gap_kl_ready", kl_ready, 1'b1);
        chk1("gap_we", ram_we, 1'b0);
        chk1("gap_keys_ok", keys_ok, keys_valid);
        tick();
      end
      kl_valid = 1'b1;
      kl_data = new_key[n];
      run_start = (n == err_beat);
      run_dec = 1'($urandom_range(0, 1));
      if (n == rst_beat) begin
        do_reset();
        return;
      end
      #1;
      chk1("ld_kl_ready", kl_ready, 1'b1);
      chk1("ld_we", ram_we, 1'b1);
      chka("ld_addr", ram_d_a, n);
      chk("ld_data", ram_d, new_key[n]);
      chk1("ld_keys_ok", keys_ok, keys_valid);
      chk1("ld_err", run_err, (n > start) && (n - 1 == err_beat));
      chk1("ld_busy", run_busy, 1'b0);
      chk1("ld_done", run_done, 1'b0);
      tick();
      keys_valid = 1'b0;
      run_start = 1'b0;
    end
    kl_valid = 1'b0;
    #1;
    chk1("ld_keys_ok_end", keys_ok, 1'b1);
    chk1("ld_err_end", run_err, (NR - 1 == err_beat));
    keys_valid = 1'b1;
    for (int n = 0; n < NR; n++) exp_key[n] = new_key[n];
  endtask

  // One run: key index held for 'period' cycles each; hold_kl keeps a key
  // word offered throughout; rst_idx pulls reset when that index is current.
  task automatic run_keys(input bit dec, input int period, input bit hold_kl,
                          input int rst_idx);
    logic [LW-1:0] e;
    exp_q.delete();
    for (int i = 0; i < NR; i++) exp_q.push_back(LW'(dec ? NR - 1 - i : i));
    run_start = 1'b1;
    run_dec = dec;
    kl_valid = hold_kl;
    kl_data = new_key[0];
    #1;
    chk1("st_kl_ready", kl_ready, 1'b0);
    chk1("st_we", ram_we, 1'b0);
    chk1("st_busy", run_busy, 1'b0);
    tick();
    run_dec = 1'($urandom_range(0, 1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int c = 0; c < period; c++) begin
        run_next = (c == period - 1);
        run_start = 1'($urandom_range(0, 1));
        if (int'(e) == rst_idx) begin
          do_reset();
          return;
        end
        #1;
        chk1("run_busy", run_busy, 1'b1);
        chka("run_idx", run_idx, int'(e));
        chka("run_q_a", ram_q_a, int'(e));
        chk1("run_last", run_last, exp_q.size() == 0);
        chk("run_key", bram[ram_q_a], exp_key[e]);
        chk1("run_kl_ready", kl_ready, 1'b0);
        chk1("run_we", ram_we, 1'b0);
        chk1("run_done0", run_done, 1'b0);
        chk1("run_err0", run_err, 1'b0);
        tick();
      end
    end
    run_next = 1'b0;
    run_start = 1'b0;
    #1;
    chk1("done", run_done, 1'b1);
    chk1("done_busy", run_busy, 1'b0);
    chka("done_idx", run_idx, 0);
    chka("done_q_a", ram_q_a, 0);
    chk1("done_last", run_last, 1'b0);
    chk1("done_keys_ok", keys_ok, 1'b1);
    if (hold_kl) begin
      chk1("done_kl_ready", kl_ready, 1'b1);
      chk1("done_we", ram_we, 1'b1);
      chka("done_addr", ram_d_a, 0);
      keys_valid = 1'b0;
    end
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    @(negedge clk);
    tick();
    tick();
    #1;
    chk1("reset_kl_ready", kl_ready, 1'b1);
    chk1("reset_we", ram_we, 1'b0);
    chk1("reset_busy", run_busy, 1'b0);
    chka("reset_idx", run_idx, 0);
    chk1("reset_last", run_last, 1'b0);
    chk1("reset_done", run_done, 1'b0);
    chk1("reset_err", run_err, 1'b0);
    chk1("reset_keys_ok", keys_ok, 1'b0);
    chka("reset_q_a", ram_q_a, 0);
    chka("reset_d_a", ram_d_a, 0);
    rst_n = 1'b1;
    tick();

    refuse();
    gen_fixed();
    load_keys(0, 4, 0, -1);
    run_keys(1'b0, 1, 1'b0, -1);
    run_keys(1'b1, 3, 1'b0, -1);

    for (int i = 0; i < 4; i++) begin
      gen_random();
      load_keys(0, -1, 3, -1);
      run_keys(1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b0, -1);
    end

    gen_random();
    run_keys(1'b0, 1, 1'b1, -1);
    load_keys(1, -1, 0, -1);
    run_keys(1'b1, 2, 1'b0, -1);

    gen_random();
    load_keys(0, -1, 0, 5);
    refuse();

    gen_random();
    load_keys(0, -1, 1, -1);
    run_keys(1'b0, 1, 1'b0, 4);
    refuse();

    gen_random();
    load_keys(0, -1, 0, -1);
    run_keys(1'b1, 1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
